// File: rtl/control_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : control_unit_pkg
// Purpose  : Shared definitions for the multicycle control unit. Holds the
//            FSM state encoding, the instruction class codes, the IR field
//            bit positions and a small immediate sign-extension helper.
// Revision : 1.0 - initial release
// ============================================================================
package control_unit_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'b00,
        CLS_LD   = 2'b01,
        CLS_JMP  = 2'b10,
        CLS_HALT = 2'b11
    } instr_class_t;

    // Class field, common to every instruction
    localparam int c_cls_hi    = 15;
    localparam int c_cls_lo    = 14;
    // ALU fields
    localparam int c_op_hi     = 13;
    localparam int c_op_lo     = 11;
    localparam int c_ri        = 10;
    localparam int c_alu_rd_hi = 9;
    localparam int c_alu_rd_lo = 7;
    localparam int c_ra_hi     = 6;
    localparam int c_ra_lo     = 4;
    localparam int c_rb_hi     = 3;
    localparam int c_rb_lo     = 1;
    localparam int c_imm_hi    = 3;
    localparam int c_imm_lo    = 0;
    // LD fields (address field shared with the JMP target)
    localparam int c_ld_rd_hi  = 13;
    localparam int c_ld_rd_lo  = 11;
    localparam int c_addr_hi   = 10;
    localparam int c_addr_lo   = 0;
    // JMP condition bit
    localparam int c_cond      = 13;

    function automatic logic [15:0] sext4(input logic [3:0] v);
        return {{12{v[3]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : control_unit_if
// Purpose  : Memory request/acknowledge bus between the control unit and
//            instruction/data memory.
//   mem_req   : request, held until mem_ack
//   mem_addr  : word address (fetch or load)
//   mem_ack   : handshake, mem_rdata valid in the same cycle
//   mem_rdata : instruction or load data
//   master : control unit side   slave : memory side
// Revision : 1.0 - initial release
// ============================================================================
interface control_unit_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface
`default_nettype wire

// File: rtl/control_unit_ir_decode.sv
`default_nettype none
// ============================================================================
// Module   : ir_decode
// Purpose  : Purely combinational split of the instruction register into
//            class, ALU/register selects, load address, jump target/condition
//            and the sign-extended immediate.
//   i_ir        : instruction register
//   o_cls       : instruction class
//   o_codeop/o_ri/o_ra/o_rb/o_rd : ALU and register-file selects
//   o_ld_addr   : zero-extended load address
//   o_target    : zero-extended jump target
//   o_cond      : jump is conditional on the compare flag
//   o_imm       : sign-extended instr[3:0]
// Revision : 1.0 - initial release
// ============================================================================
module ir_decode
    import control_unit_pkg::*;
(
    input  wire logic [15:0] i_ir,
    output instr_class_t     o_cls,
    output logic [2:0]       o_codeop,
    output logic             o_ri,
    output logic [2:0]       o_ra,
    output logic [2:0]       o_rb,
    output logic [2:0]       o_rd,
    output logic [15:0]      o_ld_addr,
    output logic [15:0]      o_target,
    output logic             o_cond,
    output logic [15:0]      o_imm
);
    assign o_cls     = instr_class_t'(i_ir[c_cls_hi:c_cls_lo]);
    assign o_codeop  = i_ir[c_op_hi:c_op_lo];
    assign o_ri      = i_ir[c_ri];
    assign o_ra      = i_ir[c_ra_hi:c_ra_lo];
    assign o_rb      = i_ir[c_rb_hi:c_rb_lo];
    // The destination lives in a different field for loads; selecting it
    // here lets the write-back use a single rd port for both classes.
    assign o_rd      = (o_cls == CLS_LD) ? i_ir[c_ld_rd_hi:c_ld_rd_lo]
                                         : i_ir[c_alu_rd_hi:c_alu_rd_lo];
    assign o_ld_addr = {5'd0, i_ir[c_addr_hi:c_addr_lo]};
    assign o_target  = {5'd0, i_ir[c_addr_hi:c_addr_lo]};
    assign o_cond    = i_ir[c_cond];
    assign o_imm     = sext4(i_ir[c_imm_hi:c_imm_lo]);
endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module   : control_unit
// Purpose  : Multicycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT).
//            Drives an external ALU and register file; owns pc, IR, the
//            result register and the compare flag.
//   clk, rst      : clock, synchronous active-high reset
//   mem_bus       : memory request/ack bus (master side)
//   alu_codeop/alu_ri, alu_r/alu_cmp : ALU control and result
//   rf_ra/rf_rb/rf_rd, rf_we, rf_wdata : register-file control
//   imm, pc, halted : immediate operand, program counter, halt status
// Revision : 1.0 - initial release
// ============================================================================
module control_unit
    import control_unit_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    control_unit_if.master   mem_bus,
    output logic [2:0]       alu_codeop,
    output logic             alu_ri,
    input  wire logic [15:0] alu_r,
    input  wire logic        alu_cmp,
    output logic [2:0]       rf_ra,
    output logic [2:0]       rf_rb,
    output logic [2:0]       rf_rd,
    output logic             rf_we,
    output logic [15:0]      rf_wdata,
    output logic [15:0]      imm,
    output logic [15:0]      pc,
    output logic             halted
);
    state_t       r_state, w_state_nxt;
    logic [15:0]  r_pc, w_pc_nxt;
    logic [15:0]  r_ir, w_ir_nxt;
    logic [15:0]  r_result, w_result_nxt;
    logic         r_cmp, w_cmp_nxt;

    logic         w_mem_req;
    logic [15:0]  w_mem_addr;
    logic         w_rf_we;
    logic         w_halted;

    instr_class_t w_cls;
    logic [15:0]  w_ld_addr;
    logic [15:0]  w_target;
    logic         w_cond;

    ir_decode u_ir_decode (
        .i_ir      (r_ir),
        .o_cls     (w_cls),
        .o_codeop  (alu_codeop),
        .o_ri      (alu_ri),
        .o_ra      (rf_ra),
        .o_rb      (rf_rb),
        .o_rd      (rf_rd),
        .o_ld_addr (w_ld_addr),
        .o_target  (w_target),
        .o_cond    (w_cond),
        .o_imm     (imm)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_FETCH;
            r_pc     <= 16'h0000;
            r_ir     <= 16'h0000;
            r_result <= 16'h0000;
            r_cmp    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_ir     <= w_ir_nxt;
            r_result <= w_result_nxt;
            r_cmp    <= w_cmp_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_ir_nxt     = r_ir;
        w_result_nxt = r_result;
        w_cmp_nxt    = r_cmp;
        w_mem_req    = 1'b0;
        w_mem_addr   = r_pc;
        w_rf_we      = 1'b0;
        w_halted     = 1'b0;

        case (r_state)
            ST_FETCH: begin
                w_mem_req = 1'b1;
                if (mem_bus.mem_ack) begin
                    w_ir_nxt    = mem_bus.mem_rdata;
                    w_pc_nxt    = r_pc + 16'd1;
                    w_state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (w_cls)
                    CLS_ALU: w_state_nxt = ST_EXEC;
                    CLS_LD:  w_state_nxt = ST_MEM;
                    CLS_JMP: begin
                        if (!w_cond || r_cmp) begin
                            w_pc_nxt = w_target;
                        end
                        w_state_nxt = ST_FETCH;
                    end
                    default: w_state_nxt = ST_HALT;
                endcase
            end
            ST_EXEC: begin
                w_result_nxt = alu_r;
                w_cmp_nxt    = alu_cmp;
                w_state_nxt  = ST_WB;
            end
            ST_MEM: begin
                w_mem_req  = 1'b1;
                w_mem_addr = w_ld_addr;
                if (mem_bus.mem_ack) begin
                    w_result_nxt = mem_bus.mem_rdata;
                    w_state_nxt  = ST_WB;
                end
            end
            ST_WB: begin
                w_rf_we     = 1'b1;
                w_state_nxt = ST_FETCH;
            end
            ST_HALT: begin
                w_halted = 1'b1;
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    // The state register already reads FETCH during a held reset; masking
    // with rst keeps the reset cycle itself free of requests and strobes,
    // so the first real fetch lands in the cycle after rst drops.
    assign mem_bus.mem_req  = w_mem_req & ~rst;
    assign mem_bus.mem_addr = w_mem_addr;
    assign rf_we            = w_rf_we & ~rst;
    assign halted           = w_halted & ~rst;
    assign rf_wdata         = r_result;
    assign pc               = r_pc;

endmodule
`default_nettype wire
